spi_slave: RTL and testbench
============================

# spi_slave

Serial front end of the SPI wrapper. Deserialises MOSI frames into the 10-bit command/data word consumed by the RAM on `rx_data`/`rx_valid`. Serialises the RAM's 8-bit read result, returned on `tx_data`/`tx_valid`, back out on MISO. Sits directly upstream of the RAM for writes and read requests, and downstream of it for read data.

## Interface
- `RX_W`, default 10: width of the frame word sent to the RAM (2 command bits + 8 payload bits).
- `TX_W`, default 8: width of the read data returned by the RAM.
- `clk` input 1: system clock; doubles as SCK, MOSI sampled on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `SS_n` input 1: slave select, active-low; high aborts any frame.
- `MOSI` input 1: serial data in, MSB first.
- `MISO` output 1: serial data out, MSB first.
- `rx_data` output RX_W: parallel frame to RAM (`din`).
- `rx_valid` output 1: one-cycle strobe, `rx_data` valid.
- `tx_data` input TX_W: read data from RAM (`dout`).
- `tx_valid` input 1: `tx_data` valid strobe from RAM.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: `SS_n` sampled low -> CHK_CMD.
- CHK_CMD: MOSI sampled as the command bit.
  - 0 -> WRITE.
  - 1 with `rd_addr_flag`=0 -> READ_ADD.
  - 1 with `rd_addr_flag`=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA each shift exactly RX_W MOSI bits into a shift register, MSB first.
- After the RX_W-th bit:
  - `rx_data` is loaded and `rx_valid` pulses for one cycle.
  - Bits are forwarded unmodified; command prefix checking (00/01/10/11) is the RAM's job.
- `rd_addr_flag`: set when a READ_ADD frame completes; cleared when a READ_DATA frame completes. Untouched by WRITE frames.
- READ_DATA, after `rx_valid`:
  - Wait, unbounded, for `tx_valid`.
  - On `tx_valid`, latch `tx_data`, then drive TX_W bits on MISO, MSB first, one per cycle.
  - After the last bit, MISO returns to 0 and the FSM holds until `SS_n` goes high.
- WRITE / READ_ADD, after `rx_valid`: hold until `SS_n` goes high.
- `tx_valid` outside the READ_DATA wait window is ignored. A second `tx_valid` during serialisation is ignored.
- MISO is 0 whenever not serialising.

## Timing
- Reset values: `MISO`=0, `rx_data`=0, `rx_valid`=0. State = IDLE, `rd_addr_flag`=0, counters 0.
- `rst` overrides all other inputs in the same edge.
- Cycle numbering: cycle 0 is the edge where `SS_n` is sampled low in IDLE; cycle 1 samples the command bit.
- Receive:
  - Cycles 2..RX_W+1 sample payload bits.
  - `rx_valid`=1 and `rx_data` updated in cycle RX_W+2 (registered, one cycle after the last sample).
- Read data:
  - `tx_valid` sampled high at edge N -> MISO carries `tx_data[TX_W-1]` from edge N+1.
  - Bit 0 is driven at edge N+TX_W; MISO=0 from edge N+TX_W+1.
- `rx_data` holds its last value between strobes.
- `SS_n` sampled high in any non-IDLE state:
  - Next state IDLE; bit counters cleared; MISO forced 0 next cycle.
  - A partial frame produces no `rx_valid`, and `rd_addr_flag` is not modified.
- `SS_n` high in the same cycle the last bit would be sampled: abort wins, no strobe.
- `rst` mid-frame: identical to power-on reset, including clearing `rd_addr_flag`.

## Structure
- Shared package `spi_pkg`:
  - `spi_state_e` enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA).
  - `RX_W`/`TX_W` defaults.
  - Command prefix localparams: `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11.
- The same package is imported by the RAM and the bench.
- One sub-module, `spi_tx_serializer`: load on `tx_valid` when armed, TX_W-bit PISO, bit counter, busy flag.
- The FSM, receive shifter and `rd_addr_flag` live in `spi_slave`.

## Test plan
- Reset: assert `rst` with `SS_n`=0 and MOSI toggling -> all outputs 0, state IDLE; with `SS_n`=1 after release, no `rx_valid` ever.
- Write frame: `SS_n` low, MOSI 0 then 10'b00_1010_0101 -> `rx_valid` single pulse at cycle 12, `rx_data`=10'h0A5, MISO stays 0.
- Read sequence, address phase:
  - Send 1 + 10'b10_0000_0011 -> `rx_data`=10'h203, flag set.
  - Raise `SS_n`, then send 1 + 10'b11_0000_0000 -> FSM enters READ_DATA, `rx_data`=10'h300.
- Read sequence, data phase: `tx_valid` with `tx_data`=8'hC3 two cycles later -> MISO 1,1,0,0,0,0,1,1 on the next 8 edges, then 0, flag cleared.
- Abort: raise `SS_n` after 5 payload bits of a WRITE frame -> no `rx_valid`, IDLE next cycle; the following full frame 10'h155 is received correctly.
- Spurious `tx_valid` during WRITE and during MISO shifting -> MISO unaffected, no second serialisation.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI front end, the RAM behind it and the bench.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_e;

    localparam int RX_W_DEF = 10;
    localparam int TX_W_DEF = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_serializer.sv
// Parallel-in/serial-out for RAM read data: captures tx_data on an armed tx_valid,
// then presents TX_W bits on a registered MISO, MSB first.
module spi_tx_serializer #(
    parameter int TX_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            arm,
    input  logic            abort,
    input  logic            tx_valid,
    input  logic [TX_W-1:0] tx_data,
    output logic            miso
);

    localparam int CNT_W = $clog2(TX_W);

    logic [TX_W-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             miso_q, miso_d;

    // MISO lags the load by one edge, so bit 0 leaves on the TX_W-th edge after capture.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        miso_d  = 1'b0;
        if (abort) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (busy_q) begin
            miso_d  = shreg_q[TX_W-1];
            shreg_d = {shreg_q[TX_W-2:0], 1'b0};
            if (cnt_q == CNT_W'(TX_W - 1)) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (arm && tx_valid) begin
            shreg_d = tx_data;
            busy_d  = 1'b1;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            miso_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            miso_q  <= miso_d;
        end
    end

    assign miso = miso_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end: command decode, RX_W-bit frame receive with a one-cycle
// rx_valid strobe, and read-data return through spi_tx_serializer.
module spi_slave
    import spi_pkg::*;
#(
    parameter int RX_W = RX_W_DEF,
    parameter int TX_W = TX_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            SS_n,
    input  logic            MOSI,
    output logic            MISO,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
    input  logic [TX_W-1:0] tx_data,
    input  logic            tx_valid
);

    localparam int CNT_W = $clog2(RX_W + 1);

    spi_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RX_W-1:0]  shreg_q, shreg_d;
    logic [RX_W-1:0]  rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rd_addr_flag_q, rd_addr_flag_d;
    logic             rx_done_q, rx_done_d;
    logic             tx_taken_q, tx_taken_d;
    logic             in_frame;
    logic             frame_full;
    logic             tx_arm;

    assign in_frame   = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);
    assign frame_full = in_frame && (cnt_q == CNT_W'(RX_W));
    assign tx_arm     = (state_q == READ_DATA) && rx_done_q && !tx_taken_q && !SS_n;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shreg_d        = shreg_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_flag_d = rd_addr_flag_q;
        rx_done_d      = rx_done_q;
        tx_taken_d     = tx_taken_q;

        // The strobe fires one edge after the last sample, even if SS_n rises on that edge.
        if (frame_full && !rx_done_q) begin
            rx_valid_d = 1'b1;
            rx_data_d  = shreg_q;
            rx_done_d  = 1'b1;
            if (state_q == READ_ADD) rd_addr_flag_d = 1'b1;
            if (state_q == READ_DATA) rd_addr_flag_d = 1'b0;
        end
        if (tx_arm && tx_valid) tx_taken_d = 1'b1;

        case (state_q)
            IDLE: begin
                cnt_d      = '0;
                rx_done_d  = 1'b0;
                tx_taken_d = 1'b0;
                if (!SS_n) state_d = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n) state_d = IDLE;
                else if (!MOSI) state_d = WRITE;
                else if (rd_addr_flag_q) state_d = READ_DATA;
                else state_d = READ_ADD;
            end
            default: begin
                if (SS_n) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    rx_done_d  = 1'b0;
                    tx_taken_d = 1'b0;
                end else if (!frame_full) begin
                    shreg_d = {shreg_q[RX_W-2:0], MOSI};
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            shreg_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_flag_q <= 1'b0;
            rx_done_q      <= 1'b0;
            tx_taken_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shreg_q        <= shreg_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_flag_q <= rd_addr_flag_d;
            rx_done_q      <= rx_done_d;
            tx_taken_q     <= tx_taken_d;
        end
    end

    spi_tx_serializer #(
        .TX_W(TX_W)
    ) u_tx_serializer (
        .clk     (clk),
        .rst     (rst),
        .arm     (tx_arm),
        .abort   (SS_n),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .miso    (MISO)
    );

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Randomized scoreboard bench for spi_slave: frame tasks push expected strobes and
// MISO bits tagged with their edge number; a monitor pops and compares every cycle.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int RX_W = RX_W_DEF;
    localparam int TX_W = TX_W_DEF;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            SS_n = 1'b0;
    logic            MOSI = 1'b0;
    logic            tx_valid = 1'b0;
    logic [TX_W-1:0] tx_data = '0;
    logic            MISO;
    logic [RX_W-1:0] rx_data;
    logic            rx_valid;

    spi_slave #(
        .RX_W(RX_W),
        .TX_W(TX_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .SS_n    (SS_n),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_valid(tx_valid)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [RX_W-1:0] data;
        int              cyc;
    } rx_exp_t;

    typedef struct {
        logic b;
        int   cyc;
    } bit_exp_t;

    rx_exp_t         rx_q[$];
    bit_exp_t        miso_q[$];
    int              n_cmp = 0;
    int              n_err = 0;
    logic [RX_W-1:0] model_rx = '0;
    bit              rd_flag = 1'b0;
    bit              rd_window = 1'b0;
    logic            exp_v;
    logic            exp_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: everything is sampled 1 time unit after the rising edge numbered cyc.
    initial forever begin
        @(posedge clk);
        #1;
        if (rst) begin
            rx_q.delete();
            miso_q.delete();
            model_rx = '0;
        end
        exp_v = 1'b0;
        if (rx_q.size() > 0 && rx_q[0].cyc == cyc) begin
            exp_v    = 1'b1;
            model_rx = rx_q[0].data;
            void'(rx_q.pop_front());
        end
        check("rx_valid", 32'(rx_valid), 32'(exp_v));
        check("rx_data", 32'(rx_data), 32'(model_rx));
        exp_m = 1'b0;
        if (miso_q.size() > 0 && miso_q[0].cyc == cyc) begin
            exp_m = miso_q[0].b;
            void'(miso_q.pop_front());
        end
        check("MISO", 32'(MISO), 32'(exp_m));
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            MOSI     = 1'($urandom);
            tx_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic cmd, input logic [RX_W-1:0] w);
        rx_exp_t e;
        @(negedge clk);
        SS_n     = 1'b0;
        MOSI     = 1'($urandom);
        tx_valid = 1'b0;
        e.data   = w;
        e.cyc    = cyc + 1 + RX_W + 2;
        rx_q.push_back(e);
        rd_window = cmd && rd_flag;
        if (cmd) rd_flag = !rd_flag;
        @(negedge clk);
        MOSI = cmd;
        for (int i = RX_W - 1; i >= 0; i--) begin
            @(negedge clk);
            MOSI = w[i];
        end
        @(negedge clk);
        MOSI = 1'($urandom);
    endtask

    // k payload bits are sampled, then SS_n rises on the next edge; k = RX_W-1 hits the last-bit edge.
    task automatic abort_frame(input logic cmd, input int k);
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'($urandom);
        @(negedge clk);
        MOSI = cmd;
        repeat (k) begin
            @(negedge clk);
            MOSI = 1'($urandom);
        end
        @(negedge clk);
        SS_n      = 1'b1;
        rd_window = 1'b0;
    endtask

    task automatic release_ss();
        int m;
        @(negedge clk);
        SS_n     = 1'b1;
        MOSI     = 1'($urandom);
        tx_valid = 1'b0;
        m        = cyc + 1;
        while (miso_q.size() > 0 && miso_q[$].cyc >= m) void'(miso_q.pop_back());
        rd_window = 1'b0;
    endtask

    task automatic pulse_tx(input logic [TX_W-1:0] d);
        bit_exp_t b;
        int       n;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        MOSI     = 1'($urandom);
        if (rd_window && !SS_n) begin
            n = cyc + 1;
            for (int i = 0; i < TX_W; i++) begin
                b.b   = d[TX_W-1-i];
                b.cyc = n + 1 + i;
                miso_q.push_back(b);
            end
            rd_window = 1'b0;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = TX_W'($urandom);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) begin
            SS_n     = 1'($urandom);
            MOSI     = 1'($urandom);
            tx_valid = 1'($urandom);
            @(negedge clk);
        end
        rst       = 1'b0;
        SS_n      = 1'b1;
        tx_valid  = 1'b0;
        rd_flag   = 1'b0;
        rd_window = 1'b0;
    endtask

    initial begin
        int kind;
        // Reset held with SS_n low and MOSI toggling; nothing may come out.
        repeat (4) begin
            @(negedge clk);
            MOSI = ~MOSI;
        end
        rst  = 1'b0;
        SS_n = 1'b1;
        idle(5);

        send_frame(1'b0, 10'h0A5);
        pulse_tx(8'h5A);
        idle(3);
        release_ss();

        send_frame(1'b1, 10'h203);
        release_ss();
        send_frame(1'b1, 10'h300);
        idle(1);
        pulse_tx(8'hC3);
        pulse_tx(8'h3C);
        idle(10);
        release_ss();

        // Flag was cleared by the READ_DATA frame, so this is an address frame again.
        send_frame(1'b1, 10'h2AA);
        pulse_tx(8'hFF);
        idle(10);
        release_ss();

        abort_frame(1'b0, 5);
        idle(1);
        send_frame(1'b0, 10'h155);
        release_ss();
        abort_frame(1'b0, RX_W - 1);
        idle(1);
        send_frame(1'b0, 10'h0F0);
        release_ss();

        // Flag is set here; a mid-frame reset must clear it.
        @(negedge clk);
        SS_n = 1'b0;
        idle(4);
        do_reset(2);
        send_frame(1'b1, 10'h3FF);
        pulse_tx(8'h81);
        idle(10);
        release_ss();

        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 3));
            if (kind == 0) begin
                send_frame(1'b0, RX_W'($urandom));
                if ($urandom_range(0, 1) == 1) pulse_tx(TX_W'($urandom));
                idle(int'($urandom_range(0, 3)));
                release_ss();
            end else if (kind == 3) begin
                abort_frame(1'($urandom), int'($urandom_range(0, RX_W - 1)));
                idle(1);
            end else begin
                send_frame(1'b1, RX_W'($urandom));
                idle(int'($urandom_range(0, 3)));
                pulse_tx(TX_W'($urandom));
                if ($urandom_range(0, 1) == 1) pulse_tx(TX_W'($urandom));
                idle(int'($urandom_range(0, 10)));
                release_ss();
            end
        end

        idle(14);
        check("rx strobes outstanding", 32'(rx_q.size()), 32'd0);
        check("MISO bits outstanding", 32'(miso_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
